// File: rtl/sp_sync_pkg.sv
// Shared state encoding, field widths and default comma for the sync controller.
package sp_sync_pkg;
    localparam int STATE_W = 2;
    localparam int CNT_W   = 3;

    localparam logic [7:0] COMMA_DEF = 8'hBC;

    typedef enum logic [STATE_W-1:0] {
        ST_HUNT   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;
endpackage

// File: rtl/sp_slip_timer.sv
// Hunt counter, one-cycle bit-slip pulse and post-slip blanking window.
// The slip cycle itself and the SLIP_WAIT cycles after it are reported as blank.
module sp_slip_timer #(
    parameter int SLIP_TIMEOUT = 16,
    parameter int SLIP_WAIT    = 4
) (
    input  logic clk_4f,
    input  logic reset,
    input  logic clear,
    input  logic count,
    input  logic restart,
    output logic slip,
    output logic blank
);
    localparam logic [8:0] TMO  = 9'(SLIP_TIMEOUT);
    localparam logic [3:0] WAIT = 4'(SLIP_WAIT);

    logic [7:0] hunt_cnt;
    logic [3:0] wait_cnt;
    logic [8:0] hunt_nxt;

    always_comb begin
        hunt_nxt = restart ? 9'd1 : ({1'b0, hunt_cnt} + 9'd1);
    end

    assign blank = slip || (wait_cnt != 4'd0);

    always_ff @(posedge clk_4f) begin
        if (reset || clear) begin
            hunt_cnt <= 8'd0;
            wait_cnt <= 4'd0;
            slip     <= 1'b0;
        end else begin
            slip <= 1'b0;
            // the window only starts counting once the slip pulse has gone
            if (!slip && wait_cnt != 4'd0)
                wait_cnt <= wait_cnt - 4'd1;
            if (count || restart) begin
                if (hunt_nxt >= TMO) begin
                    slip     <= 1'b1;
                    hunt_cnt <= 8'd0;
                    wait_cnt <= WAIT;
                end else begin
                    hunt_cnt <= hunt_nxt[7:0];
                end
            end
        end
    end
endmodule

// File: rtl/sp_sync_ctrl.sv
// Comma-based alignment/lock controller on the deserializer byte clock; 1-cycle registered data path.
// Optional bit-slip requests while hunting are enabled with SP_SLIP_EN.
module sp_sync_ctrl
    import sp_sync_pkg::*;
#(
    parameter logic [7:0] COMMA        = COMMA_DEF,
    parameter int         LOCK_CNT     = 4,
    parameter int         LOSS_CNT     = 8,
    parameter int         SLIP_TIMEOUT = 16,
    parameter int         SLIP_WAIT    = 4
) (
    input  logic               clk_4f,
    input  logic               reset,
    input  logic [7:0]         data_input,
    input  logic               valid_in,
    input  logic               resync,
`ifdef SP_SLIP_EN
    output logic               slip,
`endif
    output logic [7:0]         data_output,
    output logic               valid_output,
    output logic               active_output,
    output logic [CNT_W-1:0]   BC_contador,
    output logic [STATE_W-1:0] lock_state
);
    localparam logic [CNT_W-1:0] LOCK_C = CNT_W'(LOCK_CNT);
    localparam logic [7:0]       LOSS_C = 8'(LOSS_CNT);

    if (LOCK_CNT < 1 || LOCK_CNT > 7) begin : g_bad_lock
        $error("LOCK_CNT must be in 1..7");
    end
    if (LOSS_CNT < 1 || LOSS_CNT > 255) begin : g_bad_loss
        $error("LOSS_CNT must be in 1..255");
    end
    if (SLIP_TIMEOUT < 1 || SLIP_TIMEOUT > 255 || SLIP_WAIT < 1 || SLIP_WAIT > 15) begin : g_bad_slip
        $error("SLIP_TIMEOUT must be in 1..255 and SLIP_WAIT in 1..15");
    end

    state_t     state;
    logic [7:0] loss_cnt;
    logic       blank;
    logic       vld;
    logic       is_comma;

    assign is_comma   = (data_input == COMMA);
    assign vld        = valid_in && !blank;
    assign lock_state = state;

`ifdef SP_SLIP_EN
    logic hunt_count;
    logic hunt_restart;
    logic hunt_clear;

    assign hunt_count   = (state == ST_HUNT) && vld && !is_comma;
    assign hunt_restart = (state == ST_CHECK) && vld && !is_comma;
    assign hunt_clear   = resync || ((state != ST_HUNT) && !hunt_restart);

    sp_slip_timer #(
        .SLIP_TIMEOUT (SLIP_TIMEOUT),
        .SLIP_WAIT    (SLIP_WAIT)
    ) u_slip_timer (
        .clk_4f  (clk_4f),
        .reset   (reset),
        .clear   (hunt_clear),
        .count   (hunt_count),
        .restart (hunt_restart),
        .slip    (slip),
        .blank   (blank)
    );
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state         <= ST_HUNT;
            loss_cnt      <= 8'd0;
            BC_contador   <= '0;
            data_output   <= 8'd0;
            valid_output  <= 1'b0;
            active_output <= 1'b0;
        end else if (resync) begin
            state         <= ST_HUNT;
            loss_cnt      <= 8'd0;
            BC_contador   <= '0;
            valid_output  <= 1'b0;
            active_output <= 1'b0;
        end else begin
            valid_output <= 1'b0;
            case (state)
                ST_HUNT: begin
                    if (vld && is_comma) begin
                        BC_contador <= CNT_W'(1);
                        if (LOCK_C == CNT_W'(1)) begin
                            state         <= ST_LOCKED;
                            active_output <= 1'b1;
                        end else begin
                            state <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (vld && is_comma) begin
                        BC_contador <= BC_contador + CNT_W'(1);
                        if (BC_contador + CNT_W'(1) == LOCK_C) begin
                            state         <= ST_LOCKED;
                            active_output <= 1'b1;
                        end
                    end else if (vld) begin
                        BC_contador <= '0;
                        state       <= ST_HUNT;
                    end
                end
                ST_LOCKED: begin
                    // exit decision uses the registered loss count, so the drop lands one edge after the gap limit
                    if (loss_cnt == LOSS_C) begin
                        state         <= ST_HUNT;
                        loss_cnt      <= 8'd0;
                        BC_contador   <= '0;
                        active_output <= 1'b0;
                    end else begin
                        data_output  <= data_input;
                        valid_output <= valid_in;
                        loss_cnt     <= valid_in ? 8'd0 : loss_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= ST_HUNT;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sp_sync_ctrl.sv
// Bench for sp_sync_ctrl: directed scenarios plus a randomized run against a comma-run reference model.
module tb_sp_sync_ctrl;
    localparam int LOCK = 4;
    localparam int LOSS = 8;
    localparam int TMO  = 16;
    localparam int WAIT = 4;
    localparam logic [7:0] COMMA = 8'hBC;

    logic       clk_4f = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_input = 8'd0;
    logic       valid_in = 1'b0;
    logic       resync = 1'b0;
    logic       slip;
    logic [7:0] data_output;
    logic       valid_output;
    logic       active_output;
    logic [2:0] BC_contador;
    logic [1:0] lock_state;

    int checks = 0;
    int failures = 0;

    // reference model: consecutive comma run, lock flag, gap length, hunt length, blank cycles left
    int         m_run, m_gap, m_hunt, m_blank;
    bit         m_locked;
    logic [7:0] e_dout;
    bit         e_vout, e_act, e_slip;

    always #5 clk_4f = ~clk_4f;

    sp_sync_ctrl #(
        .COMMA        (COMMA),
        .LOCK_CNT     (LOCK),
        .LOSS_CNT     (LOSS),
        .SLIP_TIMEOUT (TMO),
        .SLIP_WAIT    (WAIT)
    ) dut (
        .clk_4f        (clk_4f),
        .reset         (reset),
        .data_input    (data_input),
        .valid_in      (valid_in),
        .resync        (resync),
`ifdef SP_SLIP_EN
        .slip          (slip),
`endif
        .data_output   (data_output),
        .valid_output  (valid_output),
        .active_output (active_output),
        .BC_contador   (BC_contador),
        .lock_state    (lock_state)
    );

`ifndef SP_SLIP_EN
    assign slip = 1'b0;
`endif

    task automatic model_step(input bit r, input bit rs, input bit v, input logic [7:0] d);
        bit ok_v;
        e_slip = 0;
        if (r) begin
            m_run = 0; m_gap = 0; m_hunt = 0; m_blank = 0; m_locked = 0;
            e_dout = 8'd0; e_vout = 0; e_act = 0;
        end else if (rs) begin
            m_run = 0; m_gap = 0; m_hunt = 0; m_blank = 0; m_locked = 0;
            e_vout = 0; e_act = 0;
        end else if (m_locked) begin
            if (m_gap >= LOSS) begin
                m_locked = 0; m_run = 0; m_gap = 0; e_vout = 0; e_act = 0;
            end else begin
                e_dout = d; e_vout = v;
                m_gap = v ? 0 : m_gap + 1;
            end
        end else begin
            e_vout = 0;
            ok_v = v;
            if (m_blank > 0) begin
                m_blank--;
                ok_v = 0;
            end
            if (ok_v && d == COMMA) begin
                m_run++;
                m_hunt = 0;
                if (m_run == LOCK) begin
                    m_locked = 1; e_act = 1;
                end
            end else if (ok_v) begin
                m_hunt = (m_run > 0) ? 1 : m_hunt + 1;
                m_run = 0;
`ifdef SP_SLIP_EN
                if (m_hunt >= TMO) begin
                    e_slip = 1; m_hunt = 0; m_blank = WAIT + 1;
                end
`endif
            end
        end
    endtask

    // apply one cycle of inputs, let the edge happen, advance the model, settle
    task automatic drive(input bit r, input bit rs, input bit v, input logic [7:0] d);
        reset = r; resync = rs; valid_in = v; data_input = d;
        @(posedge clk_4f);
        model_step(r, rs, v, d);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 1, COMMA);
        drive(1, 1, 1, 8'h5A);
        checks++;
        if ({data_output, valid_output, active_output, BC_contador, lock_state, slip} !== 15'd0) begin
            failures++;
            $display("FAIL reset_outputs: dout=%h vout=%b act=%b bc=%0d ls=%0d slip=%b, expected all zero",
                     data_output, valid_output, active_output, BC_contador, lock_state, slip);
        end
    endtask

    task automatic test_lock();
        drive(1, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, COMMA);
            checks++;
            if (BC_contador !== 3'(i + 1) || active_output !== (i == 3)) begin
                failures++;
                $display("FAIL lock_count[%0d]: bc=%0d act=%b, expected bc=%0d act=%b",
                         i, BC_contador, active_output, i + 1, (i == 3));
            end
        end
        checks++;
        if (lock_state !== 2'd2) begin
            failures++;
            $display("FAIL lock_state: got %0d expected 2", lock_state);
        end
    endtask

    task automatic test_check_abort();
        drive(1, 0, 0, 8'h00);
        drive(0, 0, 1, COMMA);
        drive(0, 0, 1, COMMA);
        checks++;
        if (lock_state !== 2'd1 || BC_contador !== 3'd2) begin
            failures++;
            $display("FAIL check_entry: ls=%0d bc=%0d expected ls=1 bc=2", lock_state, BC_contador);
        end
        drive(0, 0, 1, 8'h55);
        checks++;
        if (BC_contador !== 3'd0 || lock_state !== 2'd0 || active_output !== 1'b0) begin
            failures++;
            $display("FAIL check_abort: bc=%0d ls=%0d act=%b expected 0 0 0",
                     BC_contador, lock_state, active_output);
        end
    endtask

    task automatic test_forward();
        test_lock();
        drive(0, 0, 1, 8'h12);
        checks++;
        if (data_output !== 8'h12 || valid_output !== 1'b1) begin
            failures++;
            $display("FAIL forward_12: dout=%h vout=%b expected 12 1", data_output, valid_output);
        end
        drive(0, 0, 1, 8'h34);
        checks++;
        if (data_output !== 8'h34 || valid_output !== 1'b1) begin
            failures++;
            $display("FAIL forward_34: dout=%h vout=%b expected 34 1", data_output, valid_output);
        end
        drive(0, 0, 1, COMMA);
        checks++;
        if (data_output !== COMMA || BC_contador !== 3'(LOCK) || active_output !== 1'b1) begin
            failures++;
            $display("FAIL forward_comma: dout=%h bc=%0d act=%b expected bc 4 act 1",
                     data_output, BC_contador, active_output);
        end
    endtask

    task automatic test_loss();
        test_lock();
        for (int i = 0; i < 7; i++) drive(0, 0, 0, 8'h00);
        drive(0, 0, 1, 8'h77);
        checks++;
        if (active_output !== 1'b1 || valid_output !== 1'b1) begin
            failures++;
            $display("FAIL loss_gap7: act=%b vout=%b expected 1 1", active_output, valid_output);
        end
        for (int i = 1; i <= 9; i++) begin
            drive(0, 0, 0, 8'h00);
            checks++;
            if (active_output !== (i < 9)) begin
                failures++;
                $display("FAIL loss_gap8 edge %0d: act=%b expected %b", i, active_output, (i < 9));
            end
        end
        checks++;
        if (lock_state !== 2'd0 || BC_contador !== 3'd0 || valid_output !== 1'b0) begin
            failures++;
            $display("FAIL loss_exit: ls=%0d bc=%0d vout=%b expected 0 0 0",
                     lock_state, BC_contador, valid_output);
        end
    endtask

    task automatic test_resync();
        drive(1, 0, 0, 8'h00);
        drive(0, 0, 1, COMMA);
        drive(0, 0, 1, COMMA);
        drive(0, 1, 1, COMMA);
        checks++;
        if (lock_state !== 2'd0 || BC_contador !== 3'd0) begin
            failures++;
            $display("FAIL resync_check: ls=%0d bc=%0d expected 0 0", lock_state, BC_contador);
        end
        test_lock();
        drive(0, 0, 1, 8'hA5);
        drive(1, 0, 1, COMMA);
        checks++;
        if ({data_output, valid_output, active_output, BC_contador, lock_state} !== 14'd0) begin
            failures++;
            $display("FAIL reset_midlock: dout=%h vout=%b act=%b bc=%0d ls=%0d expected all zero",
                     data_output, valid_output, active_output, BC_contador, lock_state);
        end
    endtask

    task automatic test_slip();
        drive(1, 0, 0, 8'h00);
`ifdef SP_SLIP_EN
        for (int i = 1; i <= TMO; i++) begin
            drive(0, 0, 1, 8'h00);
            checks++;
            if (slip !== (i == TMO)) begin
                failures++;
                $display("FAIL slip_pulse byte %0d: slip=%b expected %b", i, slip, (i == TMO));
            end
        end
        for (int i = 0; i <= WAIT; i++) begin
            drive(0, 0, 1, COMMA);
            checks++;
            if (slip !== 1'b0 || BC_contador !== 3'd0) begin
                failures++;
                $display("FAIL slip_blank %0d: slip=%b bc=%0d expected 0 0", i, slip, BC_contador);
            end
        end
        drive(0, 0, 1, COMMA);
        checks++;
        if (BC_contador !== 3'd1) begin
            failures++;
            $display("FAIL slip_after_blank: bc=%0d expected 1", BC_contador);
        end
`else
        for (int i = 0; i < 100; i++) begin
            drive(0, 0, 1, 8'h00);
            checks++;
            if (lock_state !== 2'd0 || BC_contador !== 3'd0) begin
                failures++;
                $display("FAIL hunt_idle %0d: ls=%0d bc=%0d expected 0 0", i, lock_state, BC_contador);
            end
        end
`endif
    endtask

    task automatic test_random();
        int         low_burst;
        bit         r, rs, v;
        logic [7:0] d;
        logic [2:0] xbc;
        logic [1:0] xls;
        low_burst = 0;
        drive(1, 0, 0, 8'h00);
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 999) < 4);
            rs = ($urandom_range(0, 99) < 2);
            if (low_burst > 0) begin
                v = 0;
                low_burst--;
            end else if ($urandom_range(0, 99) < 4) begin
                v = 0;
                low_burst = $urandom_range(5, 10);
            end else begin
                v = ($urandom_range(0, 99) < 85);
            end
            d = ($urandom_range(0, 99) < 55) ? COMMA : 8'($urandom_range(0, 255));
            drive(r, rs, v, d);
            xbc = m_locked ? 3'(LOCK) : 3'(m_run);
            xls = m_locked ? 2'd2 : ((m_run > 0) ? 2'd1 : 2'd0);
            checks++;
            if ({active_output, valid_output, BC_contador, lock_state, slip, data_output} !==
                {e_act, e_vout, xbc, xls, e_slip, e_dout}) begin
                failures++;
                $display("FAIL random cycle %0d: act=%b vout=%b bc=%0d ls=%0d slip=%b dout=%h, expected %b %b %0d %0d %b %h",
                         n, active_output, valid_output, BC_contador, lock_state, slip, data_output,
                         e_act, e_vout, xbc, xls, e_slip, e_dout);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_check_abort();
        test_forward();
        test_loss();
        test_resync();
        test_slip();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
